// File: rtl/func_mem_arbiter_if.sv
// Bus bundle for func_mem_arbiter: the requester-facing Avalon-MM read ports
// (m_*) and the single downstream read master port (s_*).
// The arbiter masters the downstream port and takes the 'master' modport;
// the environment (requesters + interconnect) takes 'slave'.
interface func_mem_arbiter_if #(
    parameter int NREQ = 2
);
    logic [32*NREQ-1:0] m_address;
    logic [NREQ-1:0]    m_read;
    logic [15:0]        m_readdata;
    logic [NREQ-1:0]    m_waitrequest;
    logic [31:0]        s_address;
    logic               s_read;
    logic [15:0]        s_readdata;
    logic               s_waitrequest;

    modport master (
        input  m_address,
        input  m_read,
        input  s_readdata,
        input  s_waitrequest,
        output m_readdata,
        output m_waitrequest,
        output s_address,
        output s_read
    );

    modport slave (
        output m_address,
        output m_read,
        output s_readdata,
        output s_waitrequest,
        input  m_readdata,
        input  m_waitrequest,
        input  s_address,
        input  s_read
    );
endinterface

// File: rtl/func_mem_arbiter.sv
// Round-robin read arbiter: shares one 16-bit Avalon-MM read master between
// NREQ func accelerator memory masters. A grant is held for up to HOLD
// completed reads so multi-word bursts stay together; arbitration costs one
// IDLE cycle between grants.
module func_mem_arbiter #(
    parameter int NREQ = 2,
    parameter int HOLD = 2
) (
    input  logic                clk,
    input  logic                reset,
    func_mem_arbiter_if.master  bus
);
    localparam int            GW     = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [3:0]    HOLD_C = 4'(HOLD);
    localparam logic [GW-1:0] LAST_R = GW'(NREQ - 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [GW-1:0] r_grant;
    logic [GW-1:0] w_grant_nxt;
    logic [GW-1:0] r_last;
    logic [GW-1:0] w_last_nxt;
    logic [3:0]    r_cnt;
    logic [3:0]    w_cnt_nxt;

    logic [GW-1:0] w_pick;
    logic          w_found;
    int unsigned   w_idx;
    logic [31:0]   w_gaddr;
    logic          w_gread;
    logic          w_done;

    // Rotating-priority pick: first asserted m_read scanning last+1, last+2, ...
    always_comb begin
        w_pick  = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            w_idx = (32'(r_last) + k) % NREQ;
            if (!w_found && bus.m_read[w_idx[GW-1:0]]) begin
                w_pick  = w_idx[GW-1:0];
                w_found = 1'b1;
            end
        end
    end

    // Select the granted requester's address and read strobe
    always_comb begin
        w_gaddr = '0;
        w_gread = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (r_grant == GW'(i)) begin
                w_gaddr = bus.m_address[32*i +: 32];
                w_gread = bus.m_read[i];
            end
        end
    end

    assign w_done = w_gread & ~bus.s_waitrequest;

    // Readdata is broadcast; only the granted requester samples it
    assign bus.m_readdata = bus.s_readdata;

    // Bus-side outputs: pass-through of the granted requester while in GRANT
    always_comb begin
        bus.s_address     = '0;
        bus.s_read        = 1'b0;
        bus.m_waitrequest = '1;
        if (r_state == GRANT) begin
            bus.s_address              = w_gaddr;
            bus.s_read                 = w_gread;
            bus.m_waitrequest[r_grant] = bus.s_waitrequest;
        end
    end

    // Next-state logic: arbitrate in IDLE, count completions in GRANT
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_last_nxt  = r_last;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_grant_nxt = w_pick;
                    w_cnt_nxt   = '0;
                    w_state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (!w_gread) begin
                    // Requester finished or dropped a pending read: release
                    w_last_nxt  = r_grant;
                    w_state_nxt = IDLE;
                end else if (w_done) begin
                    w_cnt_nxt = r_cnt + 4'd1;
                    if (r_cnt + 4'd1 == HOLD_C) begin
                        w_last_nxt  = r_grant;
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State registers with asynchronous reset; last starts at NREQ-1 so
    // requester 0 wins the first arbitration
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_last  <= LAST_R;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_last  <= w_last_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // At most one requester may ever see waitrequest low
    a_one_wait_low: assert property (@(posedge clk) disable iff (reset)
        $countones(~bus.m_waitrequest) <= 1);

    // Downstream read only ever issued from GRANT
    a_read_in_grant: assert property (@(posedge clk) disable iff (reset)
        bus.s_read |-> (r_state == GRANT));

    // Completion count never reaches past HOLD
    a_cnt_bound: assert property (@(posedge clk) disable iff (reset)
        r_cnt <= HOLD_C);
endmodule
